// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if
//   Bundles the operation request (valid/ready, operand, shift amount, op,
//   tag), the flush control and the result return path (valid/ready, data,
//   tag, zero, illegal) of the pipelined barrel shifter.
//   master : the side that issues operations and consumes results
//   slave  : the shifter itself
// Parameters:
//   WIDTH  data width (power of two, >= 4)
//   TAG_W  width of the sideband tag
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHW = $clog2(WIDTH);

  // request side
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [SHW-1:0]   i_shamt;
  logic [2:0]       i_op;
  logic [TAG_W-1:0] i_tag;

  // result side
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic [TAG_W-1:0] o_tag;
  logic             o_zero;
  logic             o_illegal;

  modport master (
    output i_flush, i_valid, i_data, i_shamt, i_op, i_tag, i_ready,
    input  o_ready, o_valid, o_data, o_tag, o_zero, o_illegal
  );

  modport slave (
    input  i_flush, i_valid, i_data, i_shamt, i_op, i_tag, i_ready,
    output o_ready, o_valid, o_data, o_tag, o_zero, o_illegal
  );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Pipelined multi-mode barrel shifter (SLL, SRL, SRA, ROL, ROR) with a
//   valid/ready handshake and a pass-through tag.  The shift network has
//   SHW = log2(WIDTH) levels; level k shifts by 2^k when shamt[k] is set.
//   A register stage follows every STAGE_GROUP levels and always follows the
//   last level, giving a latency of ceil(SHW/STAGE_GROUP) cycles.
//   The whole pipeline stalls together (bubbles are not squeezed out).
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_rst_n  synchronous active-low reset
//   bus      pipelined_shifter_if.slave: flush, request and result signals
module pipelined_shifter #(
  parameter int WIDTH       = 32,
  parameter int STAGE_GROUP = 2,
  parameter int TAG_W       = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pipelined_shifter_if.slave    bus
);

  localparam int          SHW  = $clog2(WIDTH);
  localparam int          NSTG = (SHW + STAGE_GROUP - 1) / STAGE_GROUP;
  localparam int unsigned WU   = WIDTH;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // One shift level by amt (a power of two, 1..WIDTH/2).  Illegal ops fall
  // through to the default and leave the data untouched.  SRA fills from the
  // sign captured at the input, not from the current partial result.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input int unsigned      amt,
    input logic [2:0]       op,
    input logic             sign
  );
    logic [WIDTH-1:0] fill_s;
    fill_s = {WIDTH{sign}} << (WU - amt);
    case (op)
      OP_SLL:  shift_level = d << amt;
      OP_SRL:  shift_level = d >> amt;
      OP_SRA:  shift_level = (d >> amt) | fill_s;
      OP_ROL:  shift_level = (d << amt) | (d >> (WU - amt));
      OP_ROR:  shift_level = (d >> amt) | (d << (WU - amt));
      default: shift_level = d;
    endcase
  endfunction

  // Stage registers; index NSTG-1 is the output stage.
  logic             valid_r [NSTG];
  logic [WIDTH-1:0] data_r  [NSTG];
  logic [SHW-1:0]   shamt_r [NSTG];
  logic [2:0]       op_r    [NSTG];
  logic             sign_r  [NSTG];
  logic [TAG_W-1:0] tag_r   [NSTG];
  logic             ill_r   [NSTG];

  // Inputs feeding each stage: the bus for stage 0, the previous stage after.
  logic             src_valid_s [NSTG];
  logic [WIDTH-1:0] src_data_s  [NSTG];
  logic [SHW-1:0]   src_shamt_s [NSTG];
  logic [2:0]       src_op_s    [NSTG];
  logic             src_sign_s  [NSTG];
  logic [TAG_W-1:0] src_tag_s   [NSTG];
  logic             src_ill_s   [NSTG];
  logic [WIDTH-1:0] nxt_data_s  [NSTG];

  logic advance_s;

  // The pipeline moves only when the output slot is empty or being drained.
  assign advance_s   = !valid_r[NSTG-1] || bus.i_ready;
  assign bus.o_ready = advance_s;

  for (genvar s = 0; s < NSTG; s++) begin : g_stage
    localparam int LO = s * STAGE_GROUP;
    localparam int HI = ((s + 1) * STAGE_GROUP > SHW) ? SHW : (s + 1) * STAGE_GROUP;

    logic [WIDTH-1:0] lvl_s;

    if (s == 0) begin : g_src_in
      assign src_valid_s[s] = bus.i_valid;
      assign src_data_s[s]  = bus.i_data;
      assign src_shamt_s[s] = bus.i_shamt;
      assign src_op_s[s]    = bus.i_op;
      assign src_sign_s[s]  = bus.i_data[WIDTH-1];
      assign src_tag_s[s]   = bus.i_tag;
      assign src_ill_s[s]   = (bus.i_op > OP_ROR);
    end else begin : g_src_reg
      assign src_valid_s[s] = valid_r[s-1];
      assign src_data_s[s]  = data_r[s-1];
      assign src_shamt_s[s] = shamt_r[s-1];
      assign src_op_s[s]    = op_r[s-1];
      assign src_sign_s[s]  = sign_r[s-1];
      assign src_tag_s[s]   = tag_r[s-1];
      assign src_ill_s[s]   = ill_r[s-1];
    end

    // Apply the shift levels LO..HI-1 that belong to this stage.
    always_comb begin
      lvl_s = src_data_s[s];
      for (int k = LO; k < HI; k++) begin
        if (src_shamt_s[s][k]) begin
          lvl_s = shift_level(lvl_s, 32'd1 << k, src_op_s[s], src_sign_s[s]);
        end else begin
          lvl_s = lvl_s;
        end
      end
    end

    assign nxt_data_s[s] = lvl_s;
  end

  // Stage state: reset beats flush, flush beats advance.  Payload registers
  // only load when a valid operation moves in, so bubbles never disturb
  // them and held results stay stable during backpressure.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NSTG; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= {WIDTH{1'b0}};
        shamt_r[i] <= {SHW{1'b0}};
        op_r[i]    <= 3'b000;
        sign_r[i]  <= 1'b0;
        tag_r[i]   <= {TAG_W{1'b0}};
        ill_r[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NSTG; i++) begin
        if (bus.i_flush) begin
          valid_r[i] <= 1'b0;
        end else if (advance_s) begin
          valid_r[i] <= src_valid_s[i];
        end else begin
          valid_r[i] <= valid_r[i];
        end

        if (advance_s && src_valid_s[i]) begin
          data_r[i]  <= nxt_data_s[i];
          shamt_r[i] <= src_shamt_s[i];
          op_r[i]    <= src_op_s[i];
          sign_r[i]  <= src_sign_s[i];
          tag_r[i]   <= src_tag_s[i];
          ill_r[i]   <= src_ill_s[i];
        end
      end
    end
  end

  assign bus.o_valid   = valid_r[NSTG-1];
  assign bus.o_data    = data_r[NSTG-1];
  assign bus.o_tag     = tag_r[NSTG-1];
  assign bus.o_illegal = ill_r[NSTG-1];
  assign bus.o_zero    = (data_r[NSTG-1] == {WIDTH{1'b0}});

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter
//   Directed checks of the 32-bit / STAGE_GROUP=2 shifter (latency 3):
//   reset, single op latency, back-to-back ops, backpressure, illegal op,
//   boundaries, flush and mid-stream reset; then 200 random operations on a
//   64-bit / STAGE_GROUP=3 instance (latency 2) against a behavioural model.
module tb_pipelined_shifter;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) sif ();
  pipelined_shifter_if #(.WIDTH(64), .TAG_W(5)) sif64 ();

  pipelined_shifter #(.WIDTH(32), .STAGE_GROUP(2), .TAG_W(5)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(sif)
  );

  pipelined_shifter #(.WIDTH(64), .STAGE_GROUP(3), .TAG_W(5)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(sif64)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                       input logic [4:0] tag);
    sif.i_valid = 1'b1;
    sif.i_op    = op;
    sif.i_data  = d;
    sif.i_shamt = sh;
    sif.i_tag   = tag;
  endtask

  task automatic idle();
    sif.i_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] d, input logic [4:0] tag,
                            input logic ill);
    chk({name, ".valid"},   64'(sif.o_valid),   64'd1);
    chk({name, ".data"},    64'(sif.o_data),    64'(d));
    chk({name, ".tag"},     64'(sif.o_tag),     64'(tag));
    chk({name, ".illegal"}, 64'(sif.o_illegal), 64'(ill));
    chk({name, ".zero"},    64'(sif.o_zero),    64'(d == 32'd0));
  endtask

  task automatic expect_empty(input string name);
    chk({name, ".valid"}, 64'(sif.o_valid), 64'd0);
  endtask

  function automatic logic [63:0] model64(input logic [2:0] op, input logic [63:0] d,
                                          input logic [5:0] sh);
    logic [127:0] dd;
    dd = {d, d};
    case (op)
      3'd0: model64 = d << sh;
      3'd1: model64 = d >> sh;
      3'd2: model64 = 64'($signed(d) >>> sh);
      3'd3: begin dd = dd << sh; model64 = dd[127:64]; end
      3'd4: begin dd = dd >> sh; model64 = dd[63:0]; end
      default: model64 = d;
    endcase
  endfunction

  logic [63:0] q_data [$];
  logic [4:0]  q_tag  [$];
  logic        q_ill  [$];
  logic [63:0] e_data;
  logic [4:0]  e_tag;
  logic        e_ill;
  int          acc;
  int          cyc;

  initial begin
    rst_n         = 1'b0;
    sif.i_flush   = 1'b0;  sif.i_valid   = 1'b0;  sif.i_ready   = 1'b1;
    sif.i_data    = 32'd0; sif.i_shamt   = 5'd0;  sif.i_op      = 3'd0;  sif.i_tag = 5'd0;
    sif64.i_flush = 1'b0;  sif64.i_valid = 1'b0;  sif64.i_ready = 1'b1;
    sif64.i_data  = 64'd0; sif64.i_shamt = 6'd0;  sif64.i_op    = 3'd0;  sif64.i_tag = 5'd0;

    // reset state
    tick();
    tick();
    chk("rst.valid",   64'(sif.o_valid),   64'd0);
    chk("rst.data",    64'(sif.o_data),    64'd0);
    chk("rst.zero",    64'(sif.o_zero),    64'd1);
    chk("rst.tag",     64'(sif.o_tag),     64'd0);
    chk("rst.illegal", 64'(sif.o_illegal), 64'd0);
    sif.i_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst.ready", 64'(sif.o_ready), 64'd1);
    sif.i_ready = 1'b1;

    // single SLL, latency 3
    drive(3'd0, 32'h0000_0001, 5'd31, 5'd7);
    tick(); idle();
    expect_empty("t1.lat1");
    tick();
    expect_empty("t1.lat2");
    tick();
    expect_out("t1.sll31", 32'h8000_0000, 5'd7, 1'b0);
    tick();
    expect_empty("t1.after");

    // back-to-back, one op per cycle
    drive(3'd1, 32'h8000_0000, 5'd4, 5'd1); tick();
    drive(3'd2, 32'h8000_0000, 5'd4, 5'd2); tick();
    drive(3'd3, 32'h8000_0001, 5'd1, 5'd3); tick();
    expect_out("t2.srl", 32'h0800_0000, 5'd1, 1'b0);
    drive(3'd4, 32'h8000_0001, 5'd1, 5'd4); tick(); idle();
    expect_out("t2.sra", 32'hF800_0000, 5'd2, 1'b0);
    tick();
    expect_out("t2.rol", 32'h0000_0003, 5'd3, 1'b0);
    tick();
    expect_out("t2.ror", 32'hC000_0000, 5'd4, 1'b0);
    tick();
    expect_empty("t2.after");

    // backpressure: three in flight, output held for 5 cycles
    drive(3'd0, 32'h0000_00FF, 5'd8,  5'd5); tick();
    drive(3'd1, 32'hF000_0000, 5'd28, 5'd6); tick();
    drive(3'd2, 32'h7FFF_FFFF, 5'd31, 5'd7); tick(); idle();
    sif.i_ready = 1'b0;
    #1;
    chk("t3.ready_low", 64'(sif.o_ready), 64'd0);
    expect_out("t3.held0", 32'h0000_FF00, 5'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("t3.held", 32'h0000_FF00, 5'd5, 1'b0);
      chk("t3.ready_held", 64'(sif.o_ready), 64'd0);
    end
    sif.i_ready = 1'b1;
    #1;
    chk("t3.ready_rel", 64'(sif.o_ready), 64'd1);
    tick();
    expect_out("t3.srl28", 32'h0000_000F, 5'd6, 1'b0);
    tick();
    expect_out("t3.sra_pos", 32'h0000_0000, 5'd7, 1'b0);
    tick();
    expect_empty("t3.after");

    // illegal op and boundaries
    drive(3'b110, 32'h1234_5678, 5'd7,  5'd9);  tick();
    drive(3'd0,   32'hFFFF_FFFF, 5'd0,  5'd10); tick();
    drive(3'd2,   32'h8000_0000, 5'd31, 5'd11); tick(); idle();
    expect_out("t4.illegal", 32'h1234_5678, 5'd9,  1'b1);
    tick();
    expect_out("t4.sll0",    32'hFFFF_FFFF, 5'd10, 1'b0);
    tick();
    expect_out("t4.sra31",   32'hFFFF_FFFF, 5'd11, 1'b0);
    tick();
    expect_empty("t4.after");

    // flush with 3 in flight and output stalled
    drive(3'd4, 32'h0000_0010, 5'd4, 5'd12); tick();
    drive(3'd0, 32'h0000_0001, 5'd1, 5'd13); tick();
    drive(3'd1, 32'h0000_0004, 5'd2, 5'd14); tick(); idle();
    sif.i_ready = 1'b0;
    expect_out("t5.pre", 32'h0000_0001, 5'd12, 1'b0);
    sif.i_flush = 1'b1;
    drive(3'd0, 32'h0000_AAAA, 5'd1, 5'd15);
    tick();
    sif.i_flush = 1'b0;
    idle();
    expect_empty("t5.flushed");
    drive(3'd3, 32'h0F00_0000, 5'd8, 5'd16);
    sif.i_ready = 1'b1;
    tick(); idle();
    expect_empty("t5.lat1");
    tick();
    expect_empty("t5.lat2");
    tick();
    expect_out("t5.fresh", 32'h0000_000F, 5'd16, 1'b0);
    tick();
    expect_empty("t5.after");

    // synchronous reset mid-stream
    drive(3'd0, 32'h0000_0003, 5'd2, 5'd17); tick();
    drive(3'd0, 32'h0000_0005, 5'd1, 5'd18); tick(); idle();
    rst_n = 1'b0;
    tick();
    chk("t6.valid",   64'(sif.o_valid),   64'd0);
    chk("t6.data",    64'(sif.o_data),    64'd0);
    chk("t6.zero",    64'(sif.o_zero),    64'd1);
    chk("t6.tag",     64'(sif.o_tag),     64'd0);
    chk("t6.illegal", 64'(sif.o_illegal), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("t6.ready", 64'(sif.o_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_empty("t6.lost");
    end

    // 64-bit, STAGE_GROUP=3: random ops with random backpressure
    acc = 0;
    cyc = 0;
    while ((acc < 200 || q_data.size() > 0) && cyc < 3000) begin
      if (acc < 200) begin
        sif64.i_valid = ($urandom_range(0, 3) != 0);
        sif64.i_data  = {$urandom, $urandom};
        sif64.i_shamt = 6'($urandom_range(0, 63));
        sif64.i_op    = 3'($urandom_range(0, 7));
        sif64.i_tag   = 5'($urandom_range(0, 31));
      end else begin
        sif64.i_valid = 1'b0;
      end
      sif64.i_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (sif64.o_valid && sif64.i_ready) begin
        if (q_data.size() == 0) begin
          chk("rand.spurious", 64'(sif64.o_valid), 64'd0);
        end else begin
          e_data = q_data.pop_front();
          e_tag  = q_tag.pop_front();
          e_ill  = q_ill.pop_front();
          chk("rand.data",    sif64.o_data,              e_data);
          chk("rand.tag",     64'(sif64.o_tag),          64'(e_tag));
          chk("rand.illegal", 64'(sif64.o_illegal),      64'(e_ill));
          chk("rand.zero",    64'(sif64.o_zero),         64'(e_data == 64'd0));
        end
      end
      if (sif64.i_valid && sif64.o_ready) begin
        q_data.push_back(model64(sif64.i_op, sif64.i_data, sif64.i_shamt));
        q_tag.push_back(sif64.i_tag);
        q_ill.push_back(sif64.i_op > 3'd4);
        acc++;
      end
      tick();
      cyc++;
    end
    sif64.i_valid = 1'b0;
    chk("rand.accepted", 64'(acc),           64'd200);
    chk("rand.drained",  64'(q_data.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
